// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient on lo, remainder on hi, with a dedicated divide-by-zero result.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] araw;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    logic [WIDTH:0]   sh;
    logic             ge;
    logic [WIDTH:0]   rem_nx;

    // Two's complement negate when neg is set; -2^(W-1) maps to itself,
    // which read as unsigned is exactly its magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic neg);
        return neg ? -v : v;
    endfunction

    // rem[WIDTH] folds in any carry out of the shift so the compare stays exact.
    assign sh     = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign ge     = rem[WIDTH] | (sh >= {1'b0, dvs});
    assign rem_nx = ge ? (sh - {1'b0, dvs}) : sh;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            araw        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            lo          <= '0;
            hi          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r      <= is_signed & a[WIDTH-1];
                        quo         <= magnitude(a, is_signed & a[WIDTH-1]);
                        dvs         <= magnitude(b, is_signed & b[WIDTH-1]);
                        araw        <= a;
                        rem         <= '0;
                        cnt         <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                        dz          <= (b == '0);
                        state       <= (b == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    // Divide-by-zero bypasses the sign fix-up entirely.
                    lo          <= dz ? '1 : magnitude(quo, sign_q);
                    hi          <= dz ? araw : magnitude(rem[WIDTH-1:0], sign_r);
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: unsigned/signed division, divide-by-zero,
// overflow, ignored starts, back-to-back operation and mid-operation reset.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        div_by_zero;

    int pass_cnt = 0;
    int total    = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .lo(lo), .hi(hi),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an operation from the current (post-edge) time; edges counts the
    // clock edges after the start edge until done is seen, or -1 on timeout.
    task automatic run_op(input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic s_i, output int edges);
        start = 1'b1; a = a_i; b = b_i; is_signed = s_i;
        @(posedge clk); #1;
        start = 1'b0;
        edges = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        total++; if (lo !== 32'h0) $display("FAIL reset_lo got=%h exp=0", lo); else pass_cnt++;
        total++; if (hi !== 32'h0) $display("FAIL reset_hi got=%h exp=0", hi); else pass_cnt++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got=%b exp=0", div_by_zero); else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_divu();
        int e;
        run_op(32'd100, 32'd7, 1'b0, e);
        total++; if (e !== 33) $display("FAIL divu_latency got=%0d exp=33", e); else pass_cnt++;
        total++; if (lo !== 32'd14) $display("FAIL divu_lo got=%0d exp=14", lo); else pass_cnt++;
        total++; if (hi !== 32'd2) $display("FAIL divu_hi got=%0d exp=2", hi); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL divu_busy_with_done got=%b exp=0", busy); else pass_cnt++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL divu_dbz got=%b exp=0", div_by_zero); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total++; if (done !== 1'b0) $display("FAIL divu_done_pulse got=%b exp=0", done); else pass_cnt++;
        total++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu_hold got=%h/%h exp=0000000e/00000002", lo, hi); else pass_cnt++;
    endtask

    task automatic test_signed();
        int e;
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, e);
        total++; if (e !== 33) $display("FAIL div_neg_latency got=%0d exp=33", e); else pass_cnt++;
        total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo got=%h exp=fffffffd", lo); else pass_cnt++;
        total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi got=%h exp=ffffffff", hi); else pass_cnt++;
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, e);
        total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_negb_lo got=%h exp=fffffffd", lo); else pass_cnt++;
        total++; if (hi !== 32'd1) $display("FAIL div_negb_hi got=%h exp=00000001", hi); else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int e;
        run_op(32'h1234_5678, 32'd0, 1'b0, e);
        total++; if (e !== 1) $display("FAIL dz_latency got=%0d exp=1", e); else pass_cnt++;
        total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL dz_lo got=%h exp=ffffffff", lo); else pass_cnt++;
        total++; if (hi !== 32'h1234_5678) $display("FAIL dz_hi got=%h exp=12345678", hi); else pass_cnt++;
        total++; if (div_by_zero !== 1'b1) $display("FAIL dz_flag got=%b exp=1", div_by_zero); else pass_cnt++;
        start = 1'b1; a = 32'd10; b = 32'd3; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (div_by_zero !== 1'b0) $display("FAIL dz_clear_on_start got=%b exp=0", div_by_zero); else pass_cnt++;
        e = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done) begin
                e = n;
                break;
            end
        end
        total++; if (e !== 33) $display("FAIL dz_next_latency got=%0d exp=33", e); else pass_cnt++;
        total++; if (lo !== 32'd3 || hi !== 32'd1) $display("FAIL dz_next_result got=%h/%h exp=00000003/00000001", lo, hi); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int e;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, e);
        total++; if (lo !== 32'h8000_0000) $display("FAIL ovf_lo got=%h exp=80000000", lo); else pass_cnt++;
        total++; if (hi !== 32'h0) $display("FAIL ovf_hi got=%h exp=00000000", hi); else pass_cnt++;
        total++; if (div_by_zero !== 1'b0) $display("FAIL ovf_dbz got=%b exp=0", div_by_zero); else pass_cnt++;
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, e);
        total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu_max_lo got=%h exp=ffffffff", lo); else pass_cnt++;
        total++; if (hi !== 32'h0) $display("FAIL divu_max_hi got=%h exp=00000000", hi); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int e;
        int n;
        logic got;
        start = 1'b1; a = 32'd1000; b = 32'd10; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; got = 1'b0;
        while (n < 100 && !got) begin
            if (n >= 3 && n <= 8) begin
                start = 1'b1; a = 32'd5; b = 32'd1; is_signed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (n == 5) begin
                total++; if (busy !== 1'b1) $display("FAIL ignore_busy got=%b exp=1", busy); else pass_cnt++;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        total++; if (n !== 33 || !got) $display("FAIL ignore_latency got=%0d exp=33", n); else pass_cnt++;
        total++; if (lo !== 32'd100 || hi !== 32'd0) $display("FAIL ignore_result got=%h/%h exp=00000064/00000000", lo, hi); else pass_cnt++;
        run_op(32'd50, 32'd7, 1'b0, e);
        total++; if (e !== 33) $display("FAIL b2b_latency got=%0d exp=33", e); else pass_cnt++;
        total++; if (lo !== 32'd7 || hi !== 32'd1) $display("FAIL b2b_result got=%h/%h exp=00000007/00000001", lo, hi); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int e;
        logic seen;
        start = 1'b1; a = 32'd100; b = 32'd3; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done); else pass_cnt++;
        total++; if (lo !== 32'h0 || hi !== 32'h0) $display("FAIL rstmid_lohi got=%h/%h exp=0/0", lo, hi); else pass_cnt++;
        @(negedge clk); rst = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL rstmid_no_done got=%b exp=0", seen); else pass_cnt++;
        run_op(32'hFFFF_FFB3, 32'd5, 1'b1, e);
        total++; if (e !== 33) $display("FAIL rstmid_fresh_latency got=%0d exp=33", e); else pass_cnt++;
        total++; if (lo !== 32'hFFFF_FFF1 || hi !== 32'hFFFF_FFFE) $display("FAIL rstmid_fresh_result got=%h/%h exp=fffffff1/fffffffe", lo, hi); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
